// File: rtl/fifo_to_ram_writer_pkg.sv
// Shared types and constants for the FIFO-to-RAM drain stage.
// Holds the FSM encoding, default bus widths and the counter-width helper.
package fifo_to_ram_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Ceiling log2, never smaller than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_to_ram_writer_if.sv
// FIFO read port plus RAM write port seen by the drain stage.
// master = the writer itself, slave = the FIFO/RAM side.
interface fifo_to_ram_writer_if
  import fifo_to_ram_writer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              fifo_rdempty;
  logic [DATA_W-1:0] fifo_out;
  logic              fifo_rdeq;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;

  modport master (
    input  fifo_rdempty, fifo_out,
    output fifo_rdeq, ram_we, ram_addr, ram_din
  );

  modport slave (
    output fifo_rdempty, fifo_out,
    input  fifo_rdeq, ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/fifo_to_ram_writer.sv
// Drains XFER_LEN words from the FIFO read port into consecutive RAM addresses
// starting at BASE_ADDR; one start pulse per transfer, one done pulse at the end.
module fifo_to_ram_writer
  import fifo_to_ram_writer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int XFER_LEN  = 32,
  parameter int BASE_ADDR = 0,
  localparam int CNT_W    = clog2(XFER_LEN + 1)
) (
  input  logic                  rvclk,
  input  logic                  rst_n,
  input  logic                  start,
  fifo_to_ram_writer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      wr_cnt
);

  localparam logic [CNT_W-1:0]  LEN_C  = CNT_W'(XFER_LEN);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(XFER_LEN - 1);
  localparam logic [CNT_W-1:0]  ONE_C  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iss_cnt;
  logic             rd_vld;
  logic             rdeq;

  always_comb begin
    state_d = state_q;
    rdeq    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // Issue limit keeps the FIFO from being over-read while the last word is in flight.
        rdeq = ~bus.fifo_rdempty & (iss_cnt < LEN_C);
        if (rd_vld && (wr_cnt == LAST_C)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: read request becomes write strobe one cycle later
  always_ff @(posedge rvclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iss_cnt <= '0;
      wr_cnt  <= '0;
      rd_vld  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_vld  <= rdeq;
      if ((state_q == IDLE) && start) begin
        iss_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (rdeq)   iss_cnt <= iss_cnt + ONE_C;
        if (rd_vld) wr_cnt  <= wr_cnt + ONE_C;
      end
    end
  end

  // Address wraps modulo 2^ADDR_W; data comes straight from the FIFO output register.
  assign bus.fifo_rdeq = rdeq;
  assign bus.ram_we    = rd_vld;
  assign bus.ram_din   = bus.fifo_out;
  assign bus.ram_addr  = BASE_C + ADDR_W'(wr_cnt);

endmodule
